dct_frame_sched: RTL and testbench

- Frame-level controller that sits in front of the DCT pre-FFT reorder stage.
- Accepts a per-frame FFT size configuration and gates the upstream sample stream into the reorder stage one frame at a time.
- Regenerates clean sop/eop from its own sample counter and throttles on frames still in flight downstream.
- Flags configuration, length and sop errors. Sample data bypasses this block; only control passes through it.

---
 rtl/dct_frame_sched_if.sv | 40 ++++
 rtl/dct_frame_sched.sv | 108 ++++++++++
 tb/tb_dct_frame_sched.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dct_frame_sched_if.sv
// ============================================================================
// dct_frame_sched_if : config, sample-control and status bundle of dct_frame_sched
// Rev 1.0
// ============================================================================
`default_nettype none

interface dct_frame_sched_if;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [11:0] cfg_fftpts;
   logic        in_valid;
   logic        in_ready;
   logic        in_sop;
   logic        in_eop;
   logic        stage_ready;
   logic        out_valid;
   logic        out_sop;
   logic        out_eop;
   logic [11:0] fftpts_out;
   logic        done_eop;
   logic        busy;
   logic        err_cfg;
   logic        err_len;
   logic        err_sop;
   logic [15:0] frame_cnt;

   modport slave (
      input  cfg_valid, cfg_fftpts, in_valid, in_sop, in_eop, stage_ready, done_eop,
      output cfg_ready, in_ready, out_valid, out_sop, out_eop, fftpts_out, busy,
             err_cfg, err_len, err_sop, frame_cnt
   );

   modport master (
      output cfg_valid, cfg_fftpts, in_valid, in_sop, in_eop, stage_ready, done_eop,
      input  cfg_ready, in_ready, out_valid, out_sop, out_eop, fftpts_out, busy,
             err_cfg, err_len, err_sop, frame_cnt
   );
endinterface

`default_nettype wire

// File: rtl/dct_frame_sched.sv
// ============================================================================
// dct_frame_sched : per-frame gate and sop/eop regenerator ahead of the reorder stage
// Rev 1.0
// ============================================================================
`default_nettype none

module dct_frame_sched #(
   parameter int MIN_PTS      = 8,
   parameter int MAX_PTS      = 2048,
   parameter int MAX_INFLIGHT = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   dct_frame_sched_if.slave   bus
);

   localparam logic [1:0]  c_idle    = 2'd0;
   localparam logic [1:0]  c_armed   = 2'd1;
   localparam logic [1:0]  c_run     = 2'd2;
   localparam logic [11:0] c_min_pts = 12'(MIN_PTS);
   localparam logic [11:0] c_max_pts = 12'(MAX_PTS);
   localparam logic [1:0]  c_max_inf = 2'(MAX_INFLIGHT);

   logic [1:0]  r_state;
   logic [11:0] r_fftpts;
   logic [11:0] r_cnt;
   logic [1:0]  r_inflight;
   logic [15:0] r_frame_cnt;
   logic        r_err_cfg;
   logic        r_err_len;
   logic        r_err_sop;

   logic w_cfg_ready, w_cfg_legal, w_cfg_acc, w_cfg_bad;
   logic w_in_ready, w_acc, w_last, w_fwd, w_sop_fwd, w_eop_fwd, w_done;
   logic w_armed, w_run;

   assign w_armed     = (r_state == c_armed);
   assign w_run       = (r_state == c_run);
   assign w_cfg_ready = (r_state == c_idle) | w_armed;
   // zero is rejected by the lower bound, so the single-bit test suffices
   assign w_cfg_legal = ((bus.cfg_fftpts & (bus.cfg_fftpts - 12'd1)) == 12'd0) &&
                        (bus.cfg_fftpts >= c_min_pts) && (bus.cfg_fftpts <= c_max_pts);
   assign w_cfg_acc   = bus.cfg_valid & w_cfg_ready & w_cfg_legal;
   assign w_cfg_bad   = bus.cfg_valid & w_cfg_ready & ~w_cfg_legal;

   assign w_in_ready  = (w_armed | w_run) & bus.stage_ready & (r_inflight < c_max_inf);
   assign w_acc       = bus.in_valid & w_in_ready;
   assign w_last      = (r_cnt == r_fftpts - 12'd1);
   assign w_fwd       = w_acc & (w_run | bus.in_sop);
   assign w_sop_fwd   = w_acc & w_armed & bus.in_sop;
   assign w_eop_fwd   = w_acc & w_run & w_last;
   assign w_done      = bus.done_eop & (r_inflight != 2'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= c_idle;
         r_fftpts    <= 12'd0;
         r_cnt       <= 12'd0;
         r_inflight  <= 2'd0;
         r_frame_cnt <= 16'd0;
         r_err_cfg   <= 1'b0;
         r_err_len   <= 1'b0;
         r_err_sop   <= 1'b0;
      end else begin
         case (r_state)
            c_idle:  if (w_cfg_acc) r_state <= c_armed;
            c_armed: if (w_sop_fwd) r_state <= c_run;
            c_run:   if (w_eop_fwd) r_state <= c_armed;
            default: r_state <= c_idle;
         endcase

         if (w_cfg_acc) r_fftpts <= bus.cfg_fftpts;

         // framing is driven purely by the count; upstream eop is only audited
         if (w_sop_fwd)
            r_cnt <= 12'd1;
         else if (w_acc && w_run)
            r_cnt <= w_last ? 12'd0 : r_cnt + 12'd1;

         case ({w_eop_fwd, w_done})
            2'b10:   r_inflight <= r_inflight + 2'd1;
            2'b01:   r_inflight <= r_inflight - 2'd1;
            default: r_inflight <= r_inflight;
         endcase

         if (w_done) r_frame_cnt <= r_frame_cnt + 16'd1;

         r_err_cfg <= w_cfg_bad;
         r_err_sop <= (w_acc & w_armed & ~bus.in_sop) | (w_acc & w_run & bus.in_sop);
         r_err_len <= (w_acc & w_run & (bus.in_eop != w_last)) | (w_sop_fwd & bus.in_eop);
      end
   end

   assign bus.cfg_ready  = w_cfg_ready;
   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = w_fwd;
   assign bus.out_sop    = w_sop_fwd;
   assign bus.out_eop    = w_eop_fwd;
   assign bus.fftpts_out = r_fftpts;
   assign bus.busy       = w_run | (r_inflight != 2'd0);
   assign bus.err_cfg    = r_err_cfg;
   assign bus.err_len    = r_err_len;
   assign bus.err_sop    = r_err_sop;
   assign bus.frame_cnt  = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_dct_frame_sched.sv
// ============================================================================
// tb_dct_frame_sched : directed scoreboard bench for dct_frame_sched
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dct_frame_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sel;
   logic        toggle;
   logic        cfg_valid, in_valid, in_sop, in_eop, stage_ready, done_eop;
   logic [11:0] cfg_fftpts;
   int          checks = 0;
   int          failures = 0;
   int          fc;
   logic [1:0]  sb[$];

   always #5 clk = ~clk;

   dct_frame_sched_if ifa ();
   dct_frame_sched_if ifb ();

   dct_frame_sched #(.MIN_PTS(8), .MAX_PTS(2048), .MAX_INFLIGHT(1)) u_dut_a (
      .clk (clk), .rst_n (rst_n), .bus (ifa.slave));
   dct_frame_sched #(.MIN_PTS(8), .MAX_PTS(2048), .MAX_INFLIGHT(2)) u_dut_b (
      .clk (clk), .rst_n (rst_n), .bus (ifb.slave));

   assign ifa.cfg_valid = cfg_valid;    assign ifb.cfg_valid = cfg_valid;
   assign ifa.cfg_fftpts = cfg_fftpts;  assign ifb.cfg_fftpts = cfg_fftpts;
   assign ifa.in_valid = in_valid;      assign ifb.in_valid = in_valid;
   assign ifa.in_sop = in_sop;          assign ifb.in_sop = in_sop;
   assign ifa.in_eop = in_eop;          assign ifb.in_eop = in_eop;
   assign ifa.stage_ready = stage_ready; assign ifb.stage_ready = stage_ready;
   assign ifa.done_eop = done_eop;      assign ifb.done_eop = done_eop;

   logic        d_cfg_ready, d_in_ready, d_out_valid, d_out_sop, d_out_eop, d_busy;
   logic        d_err_cfg, d_err_len, d_err_sop;
   logic [11:0] d_fftpts;
   logic [15:0] d_frame_cnt;

   assign d_cfg_ready = sel ? ifb.cfg_ready  : ifa.cfg_ready;
   assign d_in_ready  = sel ? ifb.in_ready   : ifa.in_ready;
   assign d_out_valid = sel ? ifb.out_valid  : ifa.out_valid;
   assign d_out_sop   = sel ? ifb.out_sop    : ifa.out_sop;
   assign d_out_eop   = sel ? ifb.out_eop    : ifa.out_eop;
   assign d_busy      = sel ? ifb.busy       : ifa.busy;
   assign d_err_cfg   = sel ? ifb.err_cfg    : ifa.err_cfg;
   assign d_err_len   = sel ? ifb.err_len    : ifa.err_len;
   assign d_err_sop   = sel ? ifb.err_sop    : ifa.err_sop;
   assign d_fftpts    = sel ? ifb.fftpts_out : ifa.fftpts_out;
   assign d_frame_cnt = sel ? ifb.frame_cnt  : ifa.frame_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals();
      chk("rst_cfg_ready", d_cfg_ready, 1);
      chk("rst_in_ready", d_in_ready, 0);
      chk("rst_out_valid", d_out_valid, 0);
      chk("rst_fftpts", d_fftpts, 0);
      chk("rst_busy", d_busy, 0);
      chk("rst_frame_cnt", d_frame_cnt, 0);
      chk("rst_errs", {d_err_cfg, d_err_len, d_err_sop}, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk_reset_vals();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic cfg(input logic [11:0] v, input logic bad, input logic [11:0] exp_pts);
      cfg_valid = 1'b1;
      cfg_fftpts = v;
      #1;
      chk("cfg_ready", d_cfg_ready, 1);
      @(posedge clk);
      @(negedge clk);
      cfg_valid = 1'b0;
      #1;
      chk("err_cfg", d_err_cfg, bad);
      chk("fftpts_out", d_fftpts, exp_pts);
   endtask

   task automatic done();
      done_eop = 1'b1;
      @(posedge clk);
      @(negedge clk);
      done_eop = 1'b0;
      #1;
   endtask

   task automatic send(input logic sop, input logic eop, input logic fwd, input logic esop,
                       input logic eeop, input logic e_err_sop, input logic e_err_len,
                       input logic dn);
      int n;
      logic [1:0] e;
      in_valid = 1'b1;
      in_sop = sop;
      in_eop = eop;
      done_eop = dn;
      if (fwd) sb.push_back({esop, eeop});
      #1;
      n = 0;
      while (!d_in_ready && n < 200) begin
         @(posedge clk);
         @(negedge clk);
         if (toggle) stage_ready = ~stage_ready;
         #1;
         n++;
      end
      if (!d_in_ready) chk("in_ready_timeout", d_in_ready, 1);
      chk("out_valid", d_out_valid, fwd);
      if (d_out_valid) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", sb.size(), 1);
         end else begin
            e = sb.pop_front();
            chk("out_sop", d_out_sop, e[1]);
            chk("out_eop", d_out_eop, e[0]);
         end
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_sop = 1'b0;
      in_eop = 1'b0;
      done_eop = 1'b0;
      if (toggle) stage_ready = ~stage_ready;
      #1;
      chk("err_sop", d_err_sop, e_err_sop);
      chk("err_len", d_err_len, e_err_len);
   endtask

   task automatic send_frame(input int n, input int eop_at, input logic dn_last);
      for (int i = 0; i < n; i++)
         send(i == 0, i == eop_at, 1'b1, i == 0, i == n - 1, 1'b0,
              (i == eop_at) != (i == n - 1), dn_last && (i == n - 1));
      chk("sb_empty", sb.size(), 0);
   endtask

   initial begin
      rst_n = 1'b0; sel = 1'b0; toggle = 1'b0;
      cfg_valid = 1'b0; cfg_fftpts = 12'd0; in_valid = 1'b0; in_sop = 1'b0;
      in_eop = 1'b0; stage_ready = 1'b1; done_eop = 1'b0; fc = 0;
      @(negedge clk);
      do_reset();

      // legal 16-point frame, then throttled until the stage reports completion
      cfg(12'd16, 1'b0, 12'd16);
      send_frame(16, 15, 1'b0);
      chk("t1_busy", d_busy, 1);
      chk("t1_in_ready_blocked", d_in_ready, 0);
      chk("t1_frame_cnt_pre", d_frame_cnt, 0);
      done();
      fc++;
      chk("t1_frame_cnt", d_frame_cnt, fc);
      chk("t1_busy_clear", d_busy, 0);
      chk("t1_in_ready", d_in_ready, 1);

      do_reset();
      fc = 0;
      cfg(12'd24, 1'b1, 12'd0);
      chk("t2_idle_24", d_in_ready, 0);
      cfg(12'd4, 1'b1, 12'd0);
      chk("t2_idle_4", d_in_ready, 0);
      cfg(12'(4096), 1'b1, 12'd0);
      chk("t2_idle_4096", d_in_ready, 0);
      cfg(12'd2048, 1'b0, 12'd2048);
      send_frame(2048, 2047, 1'b0);
      done();
      fc++;
      chk("t2_frame_cnt", d_frame_cnt, fc);

      // missing sop: samples dropped until a sop arrives
      cfg(12'd8, 1'b0, 12'd8);
      for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      send_frame(8, 7, 1'b0);
      done();
      fc++;

      // early in_eop: err_len on sample 5 and on the unmarked last sample
      send_frame(8, 5, 1'b0);
      done();
      fc++;
      chk("t4_frame_cnt", d_frame_cnt, fc);

      toggle = 1'b1;
      send_frame(8, 7, 1'b0);
      toggle = 1'b0;
      stage_ready = 1'b1;
      done();
      fc++;
      chk("t5_frame_cnt", d_frame_cnt, fc);

      // reset in the middle of a frame
      for (int i = 0; i < 3; i++)
         send(i == 0, 1'b0, 1'b1, i == 0, 1'b0, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1;
      rst_n = 1'b0;
      #1;
      chk_reset_vals();
      sb.delete();
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("t6_cfg_ready", d_cfg_ready, 1);
      chk("t6_in_ready", d_in_ready, 0);

      // two frames in flight; second eop coincides with completion of the first
      sel = 1'b1;
      do_reset();
      cfg(12'd8, 1'b0, 12'd8);
      send_frame(8, 7, 1'b0);
      chk("t7_in_ready", d_in_ready, 1);
      send_frame(8, 7, 1'b1);
      chk("t7_frame_cnt", d_frame_cnt, 1);
      chk("t7_busy", d_busy, 1);
      chk("t7_in_ready_after", d_in_ready, 1);
      done();
      chk("t7_frame_cnt_end", d_frame_cnt, 2);
      chk("t7_busy_end", d_busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
